// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the iterative binary-to-BCD converter.
package bin2bcd_seq_pkg;

  // Width of one packed BCD digit.
  localparam int BCD_W = 4;

  // Converter control states.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Smallest digit count that holds any bin_w-bit unsigned value.
  // This equals ceil(bin_w * log10(2)).
  // Computed as the smallest d with 10^d >= 2^bin_w.
  // A power of ten never equals a power of two, so the result is exact.
  function automatic int min_digits(input int bin_w);
    longint unsigned lim;
    longint unsigned p10;
    int d;
    lim = 64'd1 << bin_w;
    p10 = 64'd1;
    d   = 0;
    for (int k = 0; k < 20; k++) begin
      if (p10 < lim) begin
        p10 = p10 * 64'd10;
        d   = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// One double-dabble correction cell.
// Adds 3 to a BCD digit that is 5 or more, so that the following left
// shift carries correctly into the next decimal digit.
module bcd_digit_adj
  import bin2bcd_seq_pkg::*;
(
  input  logic [BCD_W-1:0] din,
  output logic [BCD_W-1:0] dout
);

  // Add-3-if-at-least-5 correction.
  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Bits that fall off the top digit set a sticky carry flag.
// That flag reports results that did not fit in DIGITS digits.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin_in,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] bcd_out,
  output logic                    overflow
);

  localparam int ACC_W = BCD_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t             state;
  state_t             state_nxt;
  logic [BIN_W-1:0]   shreg;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W-1:0]   acc_shift;
  logic               carry;
  logic               top_bit;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               last_step;

  // Every accumulator digit is corrected in parallel before the shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (acc[g*BCD_W +: BCD_W]),
      .dout (acc_adj[g*BCD_W +: BCD_W])
    );
  end

  // Shift {corrected accumulator, shift register} left by one.
  // The bit leaving the top digit is top_bit.
  always_comb begin
    acc_shift = {acc_adj[ACC_W-2:0], shreg[BIN_W-1]};
    top_bit   = acc_adj[ACC_W-1];
  end

  // Next-state and handshake decode.
  // start is only honoured while idle, so a start during a conversion is dropped.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    accept    = 1'b0;
    last_step = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == CNT_W'(1)) begin
          last_step = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  // Reset wins over a simultaneous start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath.
  // Capture the input on accept, then shift once per cycle.
  // On the final step, publish the result with a one-cycle done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      bcd_out  <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        shreg <= bin_in;
        acc   <= '0;
        carry <= 1'b0;
        cnt   <= CNT_W'(BIN_W);
      end else if (state == SHIFT) begin
        shreg <= {shreg[BIN_W-2:0], 1'b0};
        acc   <= acc_shift;
        carry <= carry | top_bit;
        cnt   <= cnt - 1'b1;
        if (last_step) begin
          bcd_out  <= acc_shift;
          overflow <= carry | top_bit;
          done     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq.
// Three configurations are exercised: 16/5, 10/3 (undersized) and 8/3.
// A scoreboard predicts each accepted conversion and its due cycle.
module tb_bin2bcd_seq;
  import bin2bcd_seq_pkg::*;

  localparam int WID[3] = '{16, 10, 8};
  localparam int DIG[3] = '{min_digits(16), 3, 3};

  typedef struct {
    int          inst;
    int          due;
    logic [39:0] bcd;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start_v[3];
  logic        busy_v[3];
  logic        done_v[3];
  logic        ovf_v[3];
  logic [15:0] bin16;
  logic [9:0]  bin10;
  logic [7:0]  bin8;
  logic [19:0] bcd16;
  logic [11:0] bcd10;
  logic [11:0] bcd8;

  exp_t sb[$];
  int   next_free[3];
  int   cyc;
  int   compared;
  int   mismatched;

  bin2bcd_seq #(.BIN_W(16), .DIGITS(DIG[0])) dut16 (
    .clk(clk), .rst(rst), .start(start_v[0]), .bin_in(bin16),
    .busy(busy_v[0]), .done(done_v[0]), .bcd_out(bcd16), .overflow(ovf_v[0])
  );

  bin2bcd_seq #(.BIN_W(10), .DIGITS(3)) dut10 (
    .clk(clk), .rst(rst), .start(start_v[1]), .bin_in(bin10),
    .busy(busy_v[1]), .done(done_v[1]), .bcd_out(bcd10), .overflow(ovf_v[1])
  );

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut8 (
    .clk(clk), .rst(rst), .start(start_v[2]), .bin_in(bin8),
    .busy(busy_v[2]), .done(done_v[2]), .bcd_out(bcd8), .overflow(ovf_v[2])
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Decimal reference model: repeated divide by ten.
  // A nonzero quotient left over means the value needed more digits.
  function automatic void refModel(input logic [31:0] v, input int d,
                                   output logic [39:0] bcd, output logic ovf);
    longint unsigned x;
    x   = 64'(v);
    bcd = '0;
    for (int k = 0; k < d; k++) begin
      bcd[4*k +: 4] = 4'(x % 64'd10);
      x = x / 64'd10;
    end
    ovf = (x != 64'd0);
  endfunction

  function automatic logic [31:0] binOf(input int i);
    case (i)
      0:       return 32'(bin16);
      1:       return 32'(bin10);
      default: return 32'(bin8);
    endcase
  endfunction

  function automatic logic [39:0] bcdOf(input int i);
    case (i)
      0:       return 40'(bcd16);
      1:       return 40'(bcd10);
      default: return 40'(bcd8);
    endcase
  endfunction

  function automatic bit pending(input int i);
    foreach (sb[k]) begin
      if (sb[k].inst == i) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic setBin(input int i, input logic [31:0] v);
    case (i)
      0:       bin16 = v[15:0];
      1:       bin10 = v[9:0];
      default: bin8  = v[7:0];
    endcase
  endtask

  // Pulse start for one cycle with the given value.
  task automatic applyStimulus(input int i, input logic [31:0] v);
    @(negedge clk);
    setBin(i, v);
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
  endtask

  // Wait until instance i is idle with nothing outstanding, within a bounded cycle budget.
  task automatic waitIdle(input int i);
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < 200 && !idle; n++) begin
      @(negedge clk);
      if (!busy_v[i] && !pending(i)) idle = 1'b1;
    end
    checkOutput($sformatf("idle_wait%0d", i), 64'(idle), 64'd1);
  endtask

  // Scoreboard monitor.
  // Predict acceptances at each edge, then check busy/done/result just after it.
  always @(posedge clk) begin
    exp_t e;
    int   found;
    cyc = cyc + 1;
    if (rst) begin
      sb.delete();
      for (int i = 0; i < 3; i++) next_free[i] = 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (start_v[i] && cyc >= next_free[i]) begin
          e.inst = i;
          e.due  = cyc + WID[i];
          refModel(binOf(i), DIG[i], e.bcd, e.ovf);
          sb.push_back(e);
          next_free[i] = cyc + WID[i] + 1;
        end
      end
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("busy%0d", i), 64'(busy_v[i]), 64'(cyc < next_free[i] - 1));
      found = -1;
      foreach (sb[k]) begin
        if (sb[k].inst == i && sb[k].due == cyc) found = k;
      end
      if (found >= 0) begin
        checkOutput($sformatf("done%0d", i), 64'(done_v[i]), 64'd1);
        checkOutput($sformatf("bcd%0d", i), 64'(bcdOf(i)), 64'(sb[found].bcd));
        checkOutput($sformatf("ovf%0d", i), 64'(ovf_v[i]), 64'(sb[found].ovf));
        sb.delete(found);
      end else if (done_v[i]) begin
        checkOutput($sformatf("done_extra%0d", i), 64'(done_v[i]), 64'd0);
      end
    end
  end

  // Main stimulus sequence.
  initial begin
    compared   = 0;
    mismatched = 0;
    cyc        = 0;
    rst        = 1'b1;
    bin16      = '0;
    bin10      = '0;
    bin8       = '0;
    for (int i = 0; i < 3; i++) begin
      start_v[i]   = 1'b0;
      next_free[i] = 0;
    end

    checkOutput("min_digits16", 64'(min_digits(16)), 64'd5);
    checkOutput("min_digits10", 64'(min_digits(10)), 64'd4);
    checkOutput("min_digits8", 64'(min_digits(8)), 64'd3);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("rst_bcd%0d", i), 64'(bcdOf(i)), 64'd0);
      checkOutput($sformatf("rst_ovf%0d", i), 64'(ovf_v[i]), 64'd0);
      checkOutput($sformatf("rst_done%0d", i), 64'(done_v[i]), 64'd0);
    end

    // Basic 16-bit conversions, including the full-scale value.
    applyStimulus(0, 32'd0);     waitIdle(0);
    applyStimulus(0, 32'd65535); waitIdle(0);
    applyStimulus(0, 32'd1234);  waitIdle(0);

    // Undersized digit count: 1023 overflows, 999 fits exactly.
    applyStimulus(1, 32'd1023); waitIdle(1);
    applyStimulus(1, 32'd999);  waitIdle(1);

    // Start held high: back-to-back conversions, and bin_in changes while busy.
    @(negedge clk);
    bin16      = 16'd42;
    start_v[0] = 1'b1;
    @(negedge clk);
    bin16 = 16'd7;
    repeat (17) @(negedge clk);
    start_v[0] = 1'b0;
    bin16      = 16'd999;
    repeat (3) @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    bin16      = 16'd55;
    waitIdle(0);

    // Reset at shift step 8 aborts the conversion with no done.
    applyStimulus(0, 32'd9999);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", 64'(busy_v[0]), 64'd0);
    checkOutput("abort_bcd", 64'(bcd16), 64'd0);
    checkOutput("abort_done", 64'(done_v[0]), 64'd0);
    repeat (20) @(negedge clk);
    applyStimulus(0, 32'd9999); waitIdle(0);

    // A few random values on both wider configurations.
    for (int n = 0; n < 6; n++) begin
      applyStimulus(0, 32'($urandom_range(0, 65535))); waitIdle(0);
      applyStimulus(1, 32'($urandom_range(0, 1023)));  waitIdle(1);
    end

    // Exhaustive 8-bit sweep.
    for (int v = 0; v < 256; v++) begin
      applyStimulus(2, 32'(v));
      waitIdle(2);
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Iterative, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It converts a BIN_W-bit unsigned value into DIGITS packed BCD digits with a start/done handshake. It sits between the binary datapath (counters, measurement results) and the seven-segment/display drivers. It replaces per-bit combinational add-3 cascades whose area grows with width.

## Interface
- BIN_W, default 16: width of the binary input; legal range 4..32.
- DIGITS, default 5: number of BCD output digits; legal range 1..10. Fewer digits than needed is legal and is flagged by `overflow`.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a conversion of `bin_in`; sampled only when idle.
- bin_in  in  BIN_W  unsigned value; captured on the edge that accepts `start`.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse; `bcd_out`/`overflow` valid and updated.
- bcd_out  out  4*DIGITS  packed BCD, digit 0 in bits [3:0]; held between conversions.
- overflow  out  1  high when the last result did not fit, i.e. value ≥ 10^DIGITS; held with `bcd_out`.

## Operation
- Two states, IDLE and SHIFT.
- In IDLE with `start`=1:
  - Capture `bin_in` into the shift register.
  - Clear the BCD accumulator (4*DIGITS bits) and the carry-out flag.
  - Load the step counter with BIN_W.
  - Go to SHIFT.
- Each SHIFT cycle:
  - Every accumulator digit ≥5 gets +3, all digits in parallel.
  - Shift {accumulator, shift register} left by 1.
  - The bit leaving the top digit is ORed into the sticky carry-out flag.
  - Decrement the counter.
- On the SHIFT cycle where the counter reaches 0:
  - Register the accumulator after that cycle's shift into `bcd_out`.
  - Register the carry-out flag OR the final shifted-out bit into `overflow`.
  - Pulse `done` and return to IDLE.
- When DIGITS is insufficient, `bcd_out` equals value mod 10^DIGITS. The lower digits remain exact because carries only propagate upward.
- `start` while busy is ignored; no queueing.
- `bin_in` changes after acceptance do not affect the running conversion.
- Reset values: state IDLE, `busy`=0, `done`=0, `bcd_out`=0, `overflow`=0, internal registers 0.
- Reset mid-conversion aborts the conversion; no `done` is produced.

## Timing
- `start` accepted on edge E.
- `busy`=1 from after E until after edge E+BIN_W.
- Shift steps occur on edges E+1..E+BIN_W.
- `done`=1, with new `bcd_out`/`overflow`, for exactly the one cycle following edge E+BIN_W.
- Latency: BIN_W cycles from accepting edge to done-valid.
- Throughput: one conversion per BIN_W+1 cycles.
- `busy` is already low while `done` is high. A `start` in the `done` cycle is accepted (back-to-back), giving the next `done` BIN_W+1 cycles later.
- `rst` has priority over `start` on the same edge.

## Structure
- Shared package:
  - state encoding (IDLE, SHIFT);
  - constant function `min_digits(BIN_W)` = ceil(BIN_W·log10 2), for instantiating parents and the bench;
  - the BCD digit width constant (4).
- Sub-module `bcd_digit_adj`: combinational per-digit add-3-if-≥5, 4-bit in/out. Instantiated DIGITS times by a generate loop.
- Step counter width: clog2(BIN_W+1).

## Test plan
- BIN_W=16, DIGITS=5, `bin_in`=0, `start` one cycle -> `done` 16 cycles later, `bcd_out`=20'h00000, `overflow`=0.
- BIN_W=16, DIGITS=5, `bin_in`=65535 -> `bcd_out`=20'h65535, `overflow`=0; `bin_in`=1234 -> 20'h01234.
- BIN_W=10, DIGITS=3, `bin_in`=1023 -> `bcd_out`=12'h023, `overflow`=1; `bin_in`=999 -> 12'h999, `overflow`=0.
- Timing and handshake:
  - `start` held high continuously with `bin_in`=42, then 7 -> `done` every 17 cycles.
  - Results 20'h00042 then 20'h00007.
  - Extra `start` pulses while busy produce no extra `done`.
  - `bin_in` changed mid-conversion has no effect.
- Reset mid-conversion:
  - Accept 9999, assert `rst` at step 8 -> `busy`=0, `bcd_out`=0, no `done`.
  - Next conversion of 9999 -> 20'h09999.
- Exhaustive sweep, BIN_W=8, DIGITS=3, all 256 inputs -> each `bcd_out` matches the decimal reference model, `overflow`=0, latency exactly 8.
